// File: rtl/shift_arbiter.sv
// Round-robin (or fixed-priority) arbiter sharing one 16-bit barrel shifter between two
// requesters, with a valid/ready response and two-pass rotate-right sequencing.
module shift_arbiter #(
    parameter int WIDTH = 16,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [3:0]       req0_amt,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [3:0]       req1_amt,
    input  logic [1:0]       req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] Shft_In,
    output logic [3:0]       Shft_Val,
    output logic             Shft_Mode,
    input  logic [WIDTH-1:0] Shft_Out
);

    typedef enum logic [1:0] {IDLE, EXEC, EXEC2, RESP} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;

    state_t           state;
    logic             rr_last;
    logic             win_id;
    logic [WIDTH-1:0] win_data;
    logic [3:0]       win_amt;
    logic [1:0]       win_op;
    logic [3:0]       op_amt;
    logic [1:0]       op_code;
    logic             op_id;
    logic [WIDTH-1:0] partial;

    // First-pass amount: ROR starts as a left shift by (16 - amt) mod 16.
    function automatic logic [3:0] pass1_val(input logic [1:0] op, input logic [3:0] amt);
        case (op)
            OP_SLL, OP_SRA: pass1_val = amt;
            OP_ROR:         pass1_val = 4'(5'd16 - {1'b0, amt});
            default:        pass1_val = 4'd0;
        endcase
    endfunction

    // The mask strips the sign fill so the second SRA pass acts as a logical shift.
    function automatic logic [WIDTH-1:0] ror_merge(input logic [WIDTH-1:0] lo_part,
                                                   input logic [WIDTH-1:0] sra_out,
                                                   input logic [3:0]       amt);
        ror_merge = lo_part | (sra_out & ({WIDTH{1'b1}} >> amt));
    endfunction

    function automatic logic [1:0] onehot(input logic id);
        onehot = id ? 2'b10 : 2'b01;
    endfunction

    always_comb begin
        win_id = 1'b0;
        gnt    = 2'b00;
        if (req == 2'b11)
            win_id = FAIR ? ~rr_last : 1'b0;
        else
            win_id = req[1];
        if (state == IDLE && req != 2'b00)
            gnt = onehot(win_id);
    end

    assign win_data = win_id ? req1_data : req0_data;
    assign win_amt  = win_id ? req1_amt  : req0_amt;
    assign win_op   = win_id ? req1_op   : req0_op;

    // Operation latches: pure data, captured on the grant and first pass only.
    always_ff @(posedge clk) begin
        if (state == IDLE && req != 2'b00) begin
            op_amt  <= win_amt;
            op_code <= win_op;
            op_id   <= win_id;
        end
        if (state == EXEC)
            partial <= Shft_Out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            Shft_In   <= '0;
            Shft_Val  <= 4'd0;
            Shft_Mode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        rr_last   <= win_id;
                        Shft_In   <= win_data;
                        Shft_Val  <= pass1_val(win_op, win_amt);
                        Shft_Mode <= (win_op == OP_SRA);
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_code == OP_ROR) begin
                        Shft_Val  <= op_amt;
                        Shft_Mode <= 1'b1;
                        state     <= EXEC2;
                    end else begin
                        rsp_data  <= Shft_Out;
                        rsp_valid <= onehot(op_id);
                        Shft_In   <= '0;
                        Shft_Val  <= 4'd0;
                        Shft_Mode <= 1'b0;
                        state     <= RESP;
                    end
                end
                EXEC2: begin
                    rsp_data  <= ror_merge(partial, Shft_Out, op_amt);
                    rsp_valid <= onehot(op_id);
                    Shft_In   <= '0;
                    Shft_Val  <= 4'd0;
                    Shft_Mode <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[op_id]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: vector table for single ops plus hand-written
// arbitration and mid-operation reset sequences; shifter modelled behaviourally.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  req0_amt, req1_amt;
    logic [1:0]  req0_op, req1_op;
    logic [1:0]  rsp_ready;

    logic [1:0]  gnt, rsp_valid;
    logic [15:0] rsp_data, sh_in, sh_out;
    logic [3:0]  sh_val;
    logic        sh_mode;

    logic [1:0]  f_gnt, f_rsp_valid;
    logic [15:0] f_rsp_data, f_sh_in, f_sh_out;
    logic [3:0]  f_sh_val;
    logic        f_sh_mode;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign sh_out   = sh_mode   ? 16'($signed(sh_in) >>> sh_val)     : 16'(sh_in << sh_val);
    assign f_sh_out = f_sh_mode ? 16'($signed(f_sh_in) >>> f_sh_val) : 16'(f_sh_in << f_sh_val);

    shift_arbiter #(.WIDTH(16), .FAIR(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .req0_data(req0_data), .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_data(req1_data), .req1_amt(req1_amt), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .Shft_In(sh_in), .Shft_Val(sh_val), .Shft_Mode(sh_mode), .Shft_Out(sh_out)
    );

    shift_arbiter #(.WIDTH(16), .FAIR(1'b0)) dut_fixed (
        .clk(clk), .rst(rst), .req(req), .gnt(f_gnt),
        .req0_data(req0_data), .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_data(req1_data), .req1_amt(req1_amt), .req1_op(req1_op),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(f_rsp_data),
        .Shft_In(f_sh_in), .Shft_Val(f_sh_val), .Shft_Mode(f_sh_mode), .Shft_Out(f_sh_out)
    );

    typedef struct {
        int          who;
        logic [15:0] data;
        logic [3:0]  amt;
        logic [1:0]  op;
        logic [15:0] expect_data;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int who, input logic [15:0] d, input logic [3:0] a,
                             input logic [1:0] o);
        if (who == 0) begin
            req0_data = d;        req0_amt = a;     req0_op = o;
            req1_data = 16'hDEAD; req1_amt = 4'd9;  req1_op = 2'b01;
        end else begin
            req1_data = d;        req1_amt = a;     req1_op = o;
            req0_data = 16'hBEEF; req0_amt = 4'd3;  req0_op = 2'b10;
        end
    endtask

    // Entered #1 after a rising edge with the DUT in IDLE; leaves it the same way.
    task automatic do_op(input vec_t v, input int idx);
        int n;
        logic [1:0] own;
        own = (v.who == 0) ? 2'b01 : 2'b10;
        drive_req(v.who, v.data, v.amt, v.op);
        req = own;
        @(negedge clk);
        chk($sformatf("v%0d gnt", idx), 32'(gnt), 32'(own));
        @(posedge clk); #1;
        req = 2'b00;
        n = 1;
        while (rsp_valid == 2'b00 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'(own));
        chk($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.expect_data));
        for (int h = 0; h < v.hold; h++) begin
            rsp_ready = ~own;
            @(posedge clk); #1;
            chk($sformatf("v%0d hold%0d valid", idx, h), 32'(rsp_valid), 32'(own));
            chk($sformatf("v%0d hold%0d data", idx, h), 32'(rsp_data), 32'(v.expect_data));
        end
        rsp_ready = own;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        chk($sformatf("v%0d valid drop", idx), 32'(rsp_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 16'h00F1,  4, 2'b00, 16'h0F10, 2, 0};
        vecs[1] = '{1, 16'h8000, 15, 2'b01, 16'hFFFF, 2, 5};
        vecs[2] = '{0, 16'h1234,  4, 2'b10, 16'h4123, 3, 0};
        vecs[3] = '{1, 16'h1234,  0, 2'b10, 16'h1234, 3, 0};
        vecs[4] = '{0, 16'h8001,  1, 2'b10, 16'hC000, 3, 0};
        vecs[5] = '{1, 16'hA5A5,  7, 2'b11, 16'hA5A5, 2, 0};
        vecs[6] = '{0, 16'h8000,  3, 2'b01, 16'hF000, 2, 2};
        vecs[7] = '{1, 16'h0001, 15, 2'b00, 16'h8000, 2, 0};

        rst = 1'b1; req = 2'b00; rsp_ready = 2'b00;
        drive_req(0, 16'h0, 4'd0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", 32'(rsp_data), 32'd0);
        chk("reset Shft_In", 32'(sh_in), 32'd0);
        chk("reset Shft_Val", 32'(sh_val), 32'd0);
        chk("reset Shft_Mode", 32'(sh_mode), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            do_op(vecs[i], i);

        // Reset during the second ROR pass: op dropped, arbitration pointer restored.
        drive_req(0, 16'h1234, 4'd4, 2'b10);
        req = 2'b01;
        @(posedge clk); #1;
        req = 2'b00;
        chk("ror pass1 Shft_In", 32'(sh_in), 32'h1234);
        chk("ror pass1 Shft_Val", 32'(sh_val), 32'd12);
        chk("ror pass1 Shft_Mode", 32'(sh_mode), 32'd0);
        @(posedge clk); #1;
        chk("ror pass2 Shft_Val", 32'(sh_val), 32'd4);
        chk("ror pass2 Shft_Mode", 32'(sh_mode), 32'd1);
        pulse_reset();
        chk("rst mid-op Shft_Val", 32'(sh_val), 32'd0);
        chk("rst mid-op Shft_In", 32'(sh_in), 32'd0);
        chk("rst mid-op rsp_data", 32'(rsp_data), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst mid-op no valid c%0d", c), 32'(rsp_valid), 32'd0);
        end
        req0_data = 16'h0003; req0_amt = 4'd1; req0_op = 2'b00;
        req1_data = 16'h0005; req1_amt = 4'd1; req1_op = 2'b00;
        req = 2'b11;
        @(negedge clk);
        chk("post-rst contention gnt", 32'(gnt), 32'b01);
        @(posedge clk); #1;
        req = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 2'b00;

        // Continuous contention: FAIR=1 alternates, FAIR=0 always serves requester 0.
        pulse_reset();
        req = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (gnt == 2'b00 && n < 8);
            chk($sformatf("rr grant %0d", k), 32'(gnt), (k % 2 == 0) ? 32'b01 : 32'b10);
            chk($sformatf("fixed grant %0d", k), 32'(f_gnt), 32'b01);
        end
        @(posedge clk); #1;
        req = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        chk("idle after drain", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
